// File: rtl/rx_data_fifo.sv
// Receive-side frame buffer: DEPTH-entry show-ahead FIFO of {stop, parity, data} words
// with occupancy, sticky overrun and head-entry error flags. Optional macro: RX_PARITY_CHECK_EN.
module rx_data_fifo #(
  parameter int DATA_W     = 7,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W+1:0] data_in,
  input  logic              rd_en,
  input  logic              ovr_clr,
  output logic [DATA_W+1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int               WORD_W    = DATA_W + 2;
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(DEPTH);

`ifdef RX_PARITY_CHECK_EN
  localparam int ENTRY_W = WORD_W + 1;
`else
  localparam int ENTRY_W = WORD_W;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count_q;
  logic               overrun_q;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign count = count_q;

  // A pop frees the slot in the same edge, so a full buffer still accepts load with rd_en.
  assign pop  = rd_en & ~empty;
  assign push = load & (~full | pop);

`ifdef RX_PARITY_CHECK_EN
  assign wr_entry = {(^data_in[DATA_W:0]) ^ 1'(ODD_PARITY), data_in};
`else
  assign wr_entry = data_in;
`endif

  // Storage carries no reset; only pointers and flags are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (load & full & ~rd_en) overrun_q <= 1'b1;
      else if (ovr_clr)         overrun_q <= 1'b0;
    end
  end

  assign overrun = overrun_q;
  assign head    = mem[rd_ptr];

  always_comb begin
    data_out  = '1;
    frame_err = 1'b0;
    if (!empty) begin
      data_out  = head[WORD_W-1:0];
      frame_err = ~head[WORD_W-1];
    end
  end

`ifdef RX_PARITY_CHECK_EN
  assign parity_err = ~empty & head[ENTRY_W-1];
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_data_fifo.sv
// Directed self-checking bench for rx_data_fifo (DATA_W=7, DEPTH=4, even parity).
module tb_rx_data_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [8:0] data_in;
  logic       rd_en;
  logic       ovr_clr;
  logic [8:0] data_out;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

`ifdef RX_PARITY_CHECK_EN
  localparam logic PERR_1C1 = 1'b1;
`else
  localparam logic PERR_1C1 = 1'b0;
`endif

  rx_data_fifo #(
    .DATA_W    (7),
    .DEPTH     (4),
    .ADDR_W    (2),
    .ODD_PARITY(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .ovr_clr   (ovr_clr),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the rising edge with strobes dropped.
  task automatic cyc(input logic l, input logic [8:0] d, input logic r, input logic c);
    load = l; data_in = d; rd_en = r; ovr_clr = c;
    @(posedge clk);
    #1;
    load = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; data_in = '0; rd_en = 1'b0; ovr_clr = 1'b0;
    #3;
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk3("rst_count", count, 3'd0);
    chk1("rst_overrun", overrun, 1'b0);
    chk9("rst_data", data_out, 9'h1FF);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk1("rst_parity_err", parity_err, 1'b0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // fill and drain
    cyc(1'b1, 9'h141, 1'b0, 1'b0);
    chk9("fill_lat", data_out, 9'h141);
    chk3("fill_cnt1", count, 3'd1);
    cyc(1'b1, 9'h142, 1'b0, 1'b0);
    cyc(1'b1, 9'h143, 1'b0, 1'b0);
    cyc(1'b1, 9'h144, 1'b0, 1'b0);
    chk1("fill_full", full, 1'b1);
    chk3("fill_cnt4", count, 3'd4);
    chk9("pop0", data_out, 9'h141);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk9("pop1", data_out, 9'h142);
    chk3("pop1_cnt", count, 3'd3);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk9("pop2", data_out, 9'h143);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk9("pop3", data_out, 9'h144);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk9("pop4_data", data_out, 9'h1FF);
    chk1("pop4_empty", empty, 1'b1);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk3("pop_empty_ignored", count, 3'd0);

    // overrun
    cyc(1'b1, 9'h101, 1'b0, 1'b0);
    cyc(1'b1, 9'h102, 1'b0, 1'b0);
    cyc(1'b1, 9'h103, 1'b0, 1'b0);
    cyc(1'b1, 9'h104, 1'b0, 1'b0);
    chk1("ovr_before", overrun, 1'b0);
    cyc(1'b1, 9'h155, 1'b0, 1'b0);
    chk1("ovr_set", overrun, 1'b1);
    chk3("ovr_cnt", count, 3'd4);
    chk9("ovr_head", data_out, 9'h101);
    cyc(1'b0, 9'h000, 1'b0, 1'b1);
    chk1("ovr_clr", overrun, 1'b0);
    cyc(1'b1, 9'h156, 1'b0, 1'b1);
    chk1("ovr_set_wins", overrun, 1'b1);
    cyc(1'b0, 9'h000, 1'b0, 1'b1);
    chk1("ovr_clr2", overrun, 1'b0);

    // simultaneous push/pop while full, then while empty
    cyc(1'b1, 9'h160, 1'b1, 1'b0);
    chk3("sim_full_cnt", count, 3'd4);
    chk1("sim_full_ovr", overrun, 1'b0);
    chk9("sim_full_head", data_out, 9'h102);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk9("sim_mid", data_out, 9'h104);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk9("sim_tail", data_out, 9'h160);
    chk3("sim_tail_cnt", count, 3'd1);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk1("sim_drained", empty, 1'b1);
    cyc(1'b1, 9'h17A, 1'b1, 1'b0);
    chk3("sim_empty_cnt", count, 3'd1);
    chk9("sim_empty_head", data_out, 9'h17A);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);

    // pointer wrap with interleaved push/pop
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 9'h180 + 9'(i), 1'b0, 1'b0);
      chk9("wrap_data", data_out, 9'h180 + 9'(i));
      cyc(1'b0, 9'h000, 1'b1, 1'b0);
    end
    chk1("wrap_empty", empty, 1'b1);
    chk1("frame_ok_empty", frame_err, 1'b0);
    cyc(1'b1, 9'h041, 1'b0, 1'b0);
    chk9("frame_head", data_out, 9'h041);
    chk1("frame_err", frame_err, 1'b1);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk1("frame_err_cleared", frame_err, 1'b0);

    // parity
    cyc(1'b1, 9'h141, 1'b0, 1'b0);
    cyc(1'b1, 9'h1C1, 1'b0, 1'b0);
    chk1("par_even", parity_err, 1'b0);
    chk1("par_frame_ok", frame_err, 1'b0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk9("par_head", data_out, 9'h1C1);
    chk1("par_bad", parity_err, PERR_1C1);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk1("par_empty", parity_err, 1'b0);

    // reset mid-stream with two entries held and overrun set
    cyc(1'b1, 9'h111, 1'b0, 1'b0);
    cyc(1'b1, 9'h112, 1'b0, 1'b0);
    cyc(1'b1, 9'h113, 1'b0, 1'b0);
    cyc(1'b1, 9'h114, 1'b0, 1'b0);
    cyc(1'b1, 9'h115, 1'b0, 1'b0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk3("pre_rst_cnt", count, 3'd2);
    chk1("pre_rst_ovr", overrun, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("mid_rst_empty", empty, 1'b1);
    chk3("mid_rst_cnt", count, 3'd0);
    chk1("mid_rst_ovr", overrun, 1'b0);
    chk9("mid_rst_data", data_out, 9'h1FF);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1'b1, 9'h1AA, 1'b0, 1'b0);
    chk9("post_rst_head", data_out, 9'h1AA);
    chk3("post_rst_cnt", count, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
